timera_counter: RTL

- TimerA counter core (TAR), directly downstream of the TimerA clock-select/pre-divider stage.
- Clocked by the undivided selected source; advances only on cycles where the pre-divider asserts its count-enable tick.
- Implements the four MC counting modes (stop, up, continuous, up/down). Produces TAR, the direction flag, the TAIFG set event and the CCR0 equal event for the capture/compare units and the interrupt logic.

---
 rtl/timera_counter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/timera_counter.sv
// TimerA TAR counter core: stop, up, continuous and up/down modes, advanced by the pre-divider tick.
// Define TIMERA_TAIFG_LATCH_EN to add the sticky TAIFG flag and its TAIFG_clr input.
module timera_counter #(
    parameter int WIDTH = 16
) (
    input  logic             SelectClock,
    input  logic             reset,
    input  logic             wTACLR,
    input  logic             tick,
    input  logic [1:0]       MC,
    input  logic [WIDTH-1:0] TACCR0,
    input  logic             wTAR,
    input  logic [WIDTH-1:0] TARin,
`ifdef TIMERA_TAIFG_LATCH_EN
    input  logic             TAIFG_clr,
    output logic             TAIFG,
`endif
    output logic [WIDTH-1:0] TAR,
    output logic             dirDown,
    output logic             TAIFG_set,
    output logic             EQU0
);

    localparam logic [1:0] MC_STOP   = 2'd0;
    localparam logic [1:0] MC_UP     = 2'd1;
    localparam logic [1:0] MC_CONT   = 2'd2;

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] tar_q, tar_d;
    logic             dir_down_q, dir_down_d;
    logic             taifg_set_q, taifg_set_d;
    logic             equ0_q, equ0_d;
    logic             count_en;
    logic             ccr0_zero;

    assign count_en  = tick && (MC != MC_STOP);
    assign ccr0_zero = (TACCR0 == ZERO);

    always_comb begin
        tar_d       = tar_q;
        dir_down_d  = dir_down_q;
        taifg_set_d = 1'b0;
        equ0_d      = 1'b0;

        if (wTAR) begin
            tar_d = TARin;
        end else if (count_en) begin
            case (MC)
                MC_UP: begin
                    dir_down_d = 1'b0;
                    if (!ccr0_zero) begin
                        // Wrapping on >= also recovers when TACCR0 is lowered below TAR.
                        if (tar_q < TACCR0) begin
                            tar_d = tar_q + ONE;
                        end else begin
                            tar_d       = ZERO;
                            taifg_set_d = 1'b1;
                        end
                    end
                end
                MC_CONT: begin
                    dir_down_d  = 1'b0;
                    tar_d       = tar_q + ONE;
                    taifg_set_d = (tar_q == ALL_ONES);
                end
                default: begin
                    if (!dir_down_q) begin
                        if (tar_q < TACCR0) begin
                            tar_d = tar_q + ONE;
                        end else if (!ccr0_zero && (tar_q != ZERO)) begin
                            dir_down_d = 1'b1;
                            tar_d      = tar_q - ONE;
                        end
                    end else begin
                        // TAR==0 while counting down only arises from a wTAR load.
                        if (tar_q > ONE) begin
                            tar_d = tar_q - ONE;
                        end else begin
                            tar_d       = ZERO;
                            dir_down_d  = 1'b0;
                            taifg_set_d = (tar_q == ONE);
                        end
                    end
                end
            endcase
            equ0_d = !ccr0_zero && (tar_d == TACCR0);
        end
    end

    always_ff @(posedge SelectClock or posedge reset or posedge wTACLR) begin
        if (reset || wTACLR) begin
            tar_q       <= ZERO;
            dir_down_q  <= 1'b0;
            taifg_set_q <= 1'b0;
            equ0_q      <= 1'b0;
        end else begin
            tar_q       <= tar_d;
            dir_down_q  <= dir_down_d;
            taifg_set_q <= taifg_set_d;
            equ0_q      <= equ0_d;
        end
    end

    assign TAR       = tar_q;
    assign dirDown   = dir_down_q;
    assign TAIFG_set = taifg_set_q;
    assign EQU0      = equ0_q;

`ifdef TIMERA_TAIFG_LATCH_EN
    logic taifg_q, taifg_d;

    // A set arriving with a clear wins so no interrupt is lost.
    always_comb begin
        taifg_d = taifg_q;
        if (taifg_set_d) begin
            taifg_d = 1'b1;
        end else if (TAIFG_clr) begin
            taifg_d = 1'b0;
        end
    end

    always_ff @(posedge SelectClock or posedge reset or posedge wTACLR) begin
        if (reset || wTACLR) begin
            taifg_q <= 1'b0;
        end else begin
            taifg_q <= taifg_d;
        end
    end

    assign TAIFG = taifg_q;
`endif

endmodule
